// File: rtl/mips_pkg.sv
// Shared widths and MEM-stage FSM state type for the MIPS pipeline slice.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ABORT
    } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads the writeback bundle, or writes a bubble
// (control cleared, data held) when load_i is low.
module mem_wb_reg #(
    parameter int DATA_W     = mips_pkg::DATA_W,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  reg_write_i,
    input  logic                  mem_to_reg_i,
    input  logic [DATA_W-1:0]     read_data_i,
    input  logic [DATA_W-1:0]     alu_result_i,
    input  logic [REG_ADDR_W-1:0] write_reg_i,
    output logic                  reg_write_o,
    output logic                  mem_to_reg_o,
    output logic [DATA_W-1:0]     read_data_o,
    output logic [DATA_W-1:0]     alu_result_o,
    output logic [REG_ADDR_W-1:0] write_reg_o
);

    logic                  reg_write_q,  reg_write_d;
    logic                  mem_to_reg_q, mem_to_reg_d;
    logic [DATA_W-1:0]     read_data_q,  read_data_d;
    logic [DATA_W-1:0]     alu_result_q, alu_result_d;
    logic [REG_ADDR_W-1:0] write_reg_q,  write_reg_d;

    always_comb begin
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        read_data_d  = read_data_q;
        alu_result_d = alu_result_q;
        write_reg_d  = write_reg_q;
        if (load_i) begin
            reg_write_d  = reg_write_i;
            mem_to_reg_d = mem_to_reg_i;
            read_data_d  = read_data_i;
            alu_result_d = alu_result_i;
            write_reg_d  = write_reg_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            write_reg_q  <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            write_reg_q  <= write_reg_d;
        end
    end

    assign reg_write_o  = reg_write_q;
    assign mem_to_reg_o = mem_to_reg_q;
    assign read_data_o  = read_data_q;
    assign alu_result_o = alu_result_q;
    assign write_reg_o  = write_reg_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MIPS data-memory access stage with req/ack handshake, upstream stall and MEM/WB register.
// Optional access timeout (ABORT state, sticky o_memErr) enabled by MEM_STAGE_TIMEOUT_EN.
module mem_wb_stage #(
    parameter int DATA_W         = mips_pkg::DATA_W,
    parameter int REG_ADDR_W     = mips_pkg::REG_ADDR_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_memToReg,
    input  logic                  i_memWrite,
    input  logic                  i_regWrite,
    input  logic                  i_memRead,
    input  logic [DATA_W-1:0]     i_aluResult,
    input  logic [DATA_W-1:0]     i_writeData,
    input  logic [REG_ADDR_W-1:0] i_writeReg,
    output logic                  o_stall,
    output logic                  o_dmemReq,
    output logic                  o_dmemWe,
    output logic [DATA_W-1:0]     o_dmemAddr,
    output logic [DATA_W-1:0]     o_dmemWData,
    input  logic                  i_dmemAck,
    input  logic [DATA_W-1:0]     i_dmemRData,
    output logic                  o_wbRegWrite,
    output logic                  o_wbMemToReg,
    output logic [DATA_W-1:0]     o_wbReadData,
    output logic [DATA_W-1:0]     o_wbAluResult,
    output logic [REG_ADDR_W-1:0] o_wbWriteReg,
    output logic                  o_memErr
);

    import mips_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    mem_state_t       state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             access, req, stall, load;
    logic [DATA_W-1:0] rd_data;

    assign access = i_memRead | i_memWrite;

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                req   = access;
                stall = access & ~i_dmemAck;
                if (access && !i_dmemAck) state_d = WAIT;
            end
            WAIT: begin
                req   = access;
                stall = access & ~i_dmemAck;
                if (i_dmemAck) state_d = IDLE;
`ifdef MEM_STAGE_TIMEOUT_EN
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) state_d = ABORT;
`endif
            end
`ifdef MEM_STAGE_TIMEOUT_EN
            ABORT: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // Counter reads 0 on the first WAIT cycle and saturates rather than wrapping.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == WAIT) wait_cnt_d = (&wait_cnt_q) ? wait_cnt_q : wait_cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    logic mem_err_q, mem_err_d;

    assign mem_err_d = mem_err_q | (state_d == ABORT);

    always_ff @(posedge i_clk) begin
        if (i_rst) mem_err_q <= 1'b0;
        else       mem_err_q <= mem_err_d;
    end

    assign o_memErr = mem_err_q;
    assign load     = ~o_stall & (state_q != ABORT);
`else
    assign o_memErr = 1'b0;
    assign load     = ~o_stall;
`endif

    assign o_dmemReq   = req & ~i_rst;
    assign o_stall     = stall & ~i_rst;
    assign o_dmemWe    = i_memWrite;
    assign o_dmemAddr  = i_aluResult;
    assign o_dmemWData = i_writeData;
    assign rd_data     = (i_memRead & ~i_memWrite) ? i_dmemRData : '0;

    mem_wb_reg #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_mem_wb_reg (
        .clk_i        (i_clk),
        .rst_i        (i_rst),
        .load_i       (load),
        .reg_write_i  (i_regWrite),
        .mem_to_reg_i (i_memToReg),
        .read_data_i  (rd_data),
        .alu_result_i (i_aluResult),
        .write_reg_i  (i_writeReg),
        .reg_write_o  (o_wbRegWrite),
        .mem_to_reg_o (o_wbMemToReg),
        .read_data_o  (o_wbReadData),
        .alu_result_o (o_wbAluResult),
        .write_reg_o  (o_wbWriteReg)
    );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: behavioural model checked every cycle plus pinned literals.
// Covers the MEM_STAGE_TIMEOUT_EN build when that macro is defined.
module tb_mem_wb_stage;

    localparam int TMO = 16;

    typedef struct {
        logic        rst, rd, wr, rw, m2r, ack;
        logic [31:0] alu, wd, rdat;
        logic [4:0]  wreg;
        logic        chk, e_stall, e_req, e_wrw, e_err;
        logic [31:0] e_wrd;
        logic [4:0]  e_wreg;
    } vec_t;

    logic        clk = 1'b0;
    vec_t        cur;
    string       cur_nm;
    vec_t        vq[$];
    string       nq[$];
    vec_t        nv;

    logic        o_stall, o_dmemReq, o_dmemWe, o_wbRegWrite, o_wbMemToReg, o_memErr;
    logic [31:0] o_dmemAddr, o_dmemWData, o_wbReadData, o_wbAluResult;
    logic [4:0]  o_wbWriteReg;

    // model state
    int          cyc = 0;
    bit          abort_now = 1'b0;
    logic        m_rw = 1'b0, m_m2r = 1'b0, m_err = 1'b0;
    logic [31:0] m_rd = '0, m_alu = '0;
    logic [4:0]  m_reg = '0;

    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(
        .DATA_W         (32),
        .REG_ADDR_W     (5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk         (clk),
        .i_rst         (cur.rst),
        .i_memToReg    (cur.m2r),
        .i_memWrite    (cur.wr),
        .i_regWrite    (cur.rw),
        .i_memRead     (cur.rd),
        .i_aluResult   (cur.alu),
        .i_writeData   (cur.wd),
        .i_writeReg    (cur.wreg),
        .o_stall       (o_stall),
        .o_dmemReq     (o_dmemReq),
        .o_dmemWe      (o_dmemWe),
        .o_dmemAddr    (o_dmemAddr),
        .o_dmemWData   (o_dmemWData),
        .i_dmemAck     (cur.ack),
        .i_dmemRData   (cur.rdat),
        .o_wbRegWrite  (o_wbRegWrite),
        .o_wbMemToReg  (o_wbMemToReg),
        .o_wbReadData  (o_wbReadData),
        .o_wbAluResult (o_wbAluResult),
        .o_wbWriteReg  (o_wbWriteReg),
        .o_memErr      (o_memErr)
    );

    task automatic drv(input string nm, input logic rst, input logic rd, input logic wr,
                       input logic rw, input logic m2r, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] wreg, input logic ack,
                       input logic [31:0] rdat);
        nv = '{rst: rst, rd: rd, wr: wr, rw: rw, m2r: m2r, ack: ack, alu: alu, wd: wd,
               rdat: rdat, wreg: wreg, chk: 1'b0, e_stall: 1'b0, e_req: 1'b0, e_wrw: 1'b0,
               e_err: 1'b0, e_wrd: '0, e_wreg: '0};
        vq.push_back(nv);
        nq.push_back(nm);
    endtask

    task automatic nop(input string nm);
        drv(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic pin(input logic st, input logic rq, input logic wrw,
                       input logic [31:0] wrd, input logic [4:0] wreg, input logic err);
        nv.chk    = 1'b1;
        nv.e_stall = st;
        nv.e_req  = rq;
        nv.e_wrw  = wrw;
        nv.e_wrd  = wrd;
        nv.e_wreg = wreg;
        nv.e_err  = err;
        vq[vq.size()-1] = nv;
    endtask

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0h, want %0h", cur_nm, what, act, exp);
        end
    endtask

    // Reference model: advances the expected writeback bundle at each clock edge.
    initial begin
        logic acc, stl;
`ifdef MEM_STAGE_TIMEOUT_EN
        int run;
        run = 0;
`endif
        forever begin
            @(posedge clk);
            cyc++;
            acc = cur.rd | cur.wr;
            if (cur.rst) begin
                m_rw = 0; m_m2r = 0; m_rd = '0; m_alu = '0; m_reg = '0; m_err = 0;
                abort_now = 0;
`ifdef MEM_STAGE_TIMEOUT_EN
                run = 0;
`endif
            end else begin
                stl = acc & ~cur.ack & ~abort_now;
                if (stl || abort_now) begin
                    m_rw = 0; m_m2r = 0;
                end else begin
                    m_rw  = cur.rw;
                    m_m2r = cur.m2r;
                    m_alu = cur.alu;
                    m_reg = cur.wreg;
                    m_rd  = (cur.rd && !cur.wr) ? cur.rdat : 32'h0;
                end
`ifdef MEM_STAGE_TIMEOUT_EN
                // one IDLE stall cycle plus TMO WAIT cycles precede the abort
                if (abort_now) begin
                    abort_now = 0;
                    run = 0;
                end else if (stl) begin
                    run++;
                    if (run == TMO + 1) begin
                        abort_now = 1;
                        m_err = 1;
                        run = 0;
                    end
                end else run = 0;
`endif
            end
        end
    end

    // Single compare process, mid-cycle.
    initial begin
        logic m_req, m_stall;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                m_req   = ~cur.rst & (cur.rd | cur.wr) & ~abort_now;
                m_stall = m_req & ~cur.ack;
                check("req",     o_dmemReq,     m_req);
                check("stall",   o_stall,       m_stall);
                check("we",      o_dmemWe,      cur.wr);
                check("addr",    o_dmemAddr,    cur.alu);
                check("wdata",   o_dmemWData,   cur.wd);
                check("wbRW",    o_wbRegWrite,  m_rw);
                check("wbM2R",   o_wbMemToReg,  m_m2r);
                check("wbRD",    o_wbReadData,  m_rd);
                check("wbALU",   o_wbAluResult, m_alu);
                check("wbReg",   o_wbWriteReg,  m_reg);
                check("memErr",  o_memErr,      m_err);
                if (cur.chk) begin
                    check("pin_stall", o_stall,      cur.e_stall);
                    check("pin_req",   o_dmemReq,    cur.e_req);
                    check("pin_wbRW",  o_wbRegWrite, cur.e_wrw);
                    check("pin_wbRD",  o_wbReadData, cur.e_wrd);
                    check("pin_wbReg", o_wbWriteReg, cur.e_wreg);
                    check("pin_err",   o_memErr,     cur.e_err);
                end
            end
        end
    end

    initial begin
        cur = '{rst: 1'b1, rd: 1'b0, wr: 1'b0, rw: 1'b0, m2r: 1'b0, ack: 1'b0, alu: '0, wd: '0,
                rdat: '0, wreg: '0, chk: 1'b0, e_stall: 1'b0, e_req: 1'b0, e_wrw: 1'b0,
                e_err: 1'b0, e_wrd: '0, e_wreg: '0};
        cur_nm = "init";

        drv("reset", 1, 1, 0, 0, 0, 32'h55, 0, 0, 0, 0);           pin(0, 0, 0, 0, 0, 0);
        drv("alu_op", 0, 0, 0, 1, 0, 32'h7, 0, 3, 0, 0);           pin(0, 0, 0, 0, 0, 0);
        nop("alu_wb");                                             pin(0, 0, 1, 0, 3, 0);
        drv("ld_zero", 0, 1, 0, 1, 1, 32'h100, 0, 8, 1, 32'hDEADBEEF); pin(0, 1, 0, 0, 0, 0);
        nop("ld_zero_wb");                                         pin(0, 0, 1, 32'hDEADBEEF, 8, 0);
        for (int k = 0; k < 3; k++) begin
            drv("ld_wait", 0, 1, 0, 1, 1, 32'h200, 0, 9, 0, 32'h11111111); pin(1, 1, 0, 0, 0, 0);
        end
        drv("ld_ack", 0, 1, 0, 1, 1, 32'h200, 0, 9, 1, 32'hCAFEF00D); pin(0, 1, 0, 0, 0, 0);
        nop("ld_wait_wb");                                         pin(0, 0, 1, 32'hCAFEF00D, 9, 0);
        drv("st", 0, 0, 1, 0, 0, 32'h40, 32'h12345678, 0, 0, 0);   pin(1, 1, 0, 0, 0, 0);
        drv("st_ack", 0, 0, 1, 0, 0, 32'h40, 32'h12345678, 0, 1, 32'hFFFFFFFF); pin(0, 1, 0, 0, 0, 0);
        nop("st_wb");                                              pin(0, 0, 0, 0, 0, 0);
        drv("rd_wr", 0, 1, 1, 1, 0, 32'h80, 32'hA5A5A5A5, 4, 1, 32'h99999999); pin(0, 1, 0, 0, 0, 0);
        nop("rdwr_wb");                                            pin(0, 0, 1, 0, 4, 0);
        drv("ack_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77);        pin(0, 0, 0, 0, 0, 0);
        nop("ack_idle_wb");                                        pin(0, 0, 0, 0, 0, 0);
        drv("rst_w0", 0, 1, 0, 1, 0, 32'h300, 0, 10, 0, 0);        pin(1, 1, 0, 0, 0, 0);
        drv("rst_w1", 0, 1, 0, 1, 0, 32'h300, 0, 10, 0, 0);        pin(1, 1, 0, 0, 0, 0);
        drv("rst_mid", 1, 1, 0, 1, 0, 32'h300, 0, 10, 0, 0);       pin(0, 0, 0, 0, 0, 0);
        nop("rst_after");                                          pin(0, 0, 0, 0, 0, 0);
        drv("post_rst", 0, 1, 0, 1, 1, 32'h500, 0, 11, 1, 32'h13579BDF); pin(0, 1, 0, 0, 0, 0);
        nop("post_rst_wb");                                        pin(0, 0, 1, 32'h13579BDF, 11, 0);
`ifdef MEM_STAGE_TIMEOUT_EN
        for (int k = 0; k <= TMO; k++) begin
            drv("tmo_wait", 0, 1, 0, 1, 1, 32'h600, 0, 12, 0, 0);
            if (k == 0 || k == TMO) pin(1, 1, 0, 0, 0, 0);
        end
        drv("tmo_abort", 0, 1, 0, 1, 1, 32'h600, 0, 12, 0, 0);     pin(0, 0, 0, 0, 0, 1);
        nop("tmo_after");                                          pin(0, 0, 0, 0, 0, 1);
        drv("late_ack", 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5);         pin(0, 0, 0, 0, 0, 1);
        drv("err_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);              pin(0, 0, 0, 0, 0, 1);
        nop("err_clr");                                            pin(0, 0, 0, 0, 0, 0);
`else
        for (int k = 0; k < TMO + 4; k++) begin
            drv("long_wait", 0, 1, 0, 1, 1, 32'h600, 0, 12, 0, 0);
            if (k == 0 || k == TMO + 3) pin(1, 1, 0, 0, 0, 0);
        end
        drv("long_ack", 0, 1, 0, 1, 1, 32'h600, 0, 12, 1, 32'h2468ACE0); pin(0, 1, 0, 0, 0, 0);
        nop("long_wb");                                            pin(0, 0, 1, 32'h2468ACE0, 12, 0);
`endif
        nop("tail");

        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            cur    = vq[i];
            cur_nm = nq[i];
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
